// File: rtl/uram_port_arb.sv
`default_nettype none
// ============================================================================
// Module      : uram_port_arb
// Description : Two-requester round-robin arbiter for a single native
//               URAM/BRAM port. Grants are combinational and single-cycle.
//               A {valid,id} shift register matching the memory read latency
//               routes each read response back to its issuer. An optional
//               zero-fill sequencer clears the array after reset before the
//               first grant is issued.
// Ports       : clk, rst                      - clock, sync active-high reset
//               rN_req/we/addr/wdata (N=0,1)  - request channel
//               rN_gnt                        - request accepted this cycle
//               rN_rvalid/rdata               - read response channel
//               mem_en/we/addr/din, mem_dout  - memory port
//               init_busy                     - zero-fill in progress
// Revision    : 1.0 - initial release
// ============================================================================
module uram_port_arb #(
    parameter int BYTES_PER_LINE = 4,
    parameter int ADDR_WIDTH     = 14,
    parameter int READ_LATENCY   = 2,
    parameter int INIT_ON_RESET  = 1,
    localparam int LINE_SIZE     = 8 * BYTES_PER_LINE
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      r0_req,
    input  logic [BYTES_PER_LINE-1:0] r0_we,
    input  logic [ADDR_WIDTH-1:0]     r0_addr,
    input  logic [LINE_SIZE-1:0]      r0_wdata,
    output logic                      r0_gnt,
    output logic                      r0_rvalid,
    output logic [LINE_SIZE-1:0]      r0_rdata,

    input  logic                      r1_req,
    input  logic [BYTES_PER_LINE-1:0] r1_we,
    input  logic [ADDR_WIDTH-1:0]     r1_addr,
    input  logic [LINE_SIZE-1:0]      r1_wdata,
    output logic                      r1_gnt,
    output logic                      r1_rvalid,
    output logic [LINE_SIZE-1:0]      r1_rdata,

    output logic                      mem_en,
    output logic [BYTES_PER_LINE-1:0] mem_we,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [LINE_SIZE-1:0]      mem_din,
    input  logic [LINE_SIZE-1:0]      mem_dout,

    output logic                      init_busy
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [0:0]            C_RESET_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
    localparam logic [ADDR_WIDTH-1:0] C_CNT_ONE     = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [0:0]              state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q,   cnt_d;
    // last_q = 1 means requester 1 was granted most recently.
    logic                    last_q,  last_d;
    logic [READ_LATENCY-1:0] pv_q,    pv_d;
    logic [READ_LATENCY-1:0] pid_q,   pid_d;

    logic w_run;
    logic w_init;
    logic w_g0;
    logic w_g1;
    logic w_push;

    // Reset forces every handshake/strobe output low regardless of state.
    assign w_run  = (state_q == ST_RUN)  && !rst;
    assign w_init = (state_q == ST_INIT) && !rst;

    // On a tie the requester that was not granted last wins.
    assign w_g0 = w_run && r0_req && (!r1_req ||  last_q);
    assign w_g1 = w_run && r1_req && (!r0_req || !last_q);

    assign r0_gnt = w_g0;
    assign r1_gnt = w_g1;

    assign w_push = (w_g0 && (r0_we == '0)) || (w_g1 && (r1_we == '0));

    // Memory port drive: fill sequencer, granted requester, or idle.
    always_comb begin
        mem_en   = 1'b0;
        mem_we   = '0;
        mem_addr = '0;
        mem_din  = '0;
        if (w_init) begin
            mem_en   = 1'b1;
            mem_we   = {BYTES_PER_LINE{1'b1}};
            mem_addr = cnt_q;
        end else if (w_g0) begin
            mem_en   = 1'b1;
            mem_we   = r0_we;
            mem_addr = r0_addr;
            mem_din  = r0_wdata;
        end else if (w_g1) begin
            mem_en   = 1'b1;
            mem_we   = r1_we;
            mem_addr = r1_addr;
            mem_din  = r1_wdata;
        end
    end

    // Next-state logic for sequencer, round-robin pointer and read pipe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        pv_d    = '0;
        pid_d   = '0;

        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + C_CNT_ONE;
            if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                state_d = ST_RUN;
            end
        end

        if (w_g0) begin
            last_d = 1'b0;
        end else if (w_g1) begin
            last_d = 1'b1;
        end

        // Stage 0 takes the new entry; stage k becomes visible k+1 cycles
        // after the grant, so the last stage lines up with mem_dout.
        pv_d[0]  = w_push;
        pid_d[0] = w_g1;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pv_d[i]  = pv_q[i-1];
            pid_d[i] = pid_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= C_RESET_STATE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            pv_q    <= '0;
            pid_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            pv_q    <= pv_d;
            pid_q   <= pid_d;
        end
    end

    assign r0_rvalid = !rst && pv_q[READ_LATENCY-1] && !pid_q[READ_LATENCY-1];
    assign r1_rvalid = !rst && pv_q[READ_LATENCY-1] &&  pid_q[READ_LATENCY-1];
    assign r0_rdata  = mem_dout;
    assign r1_rdata  = mem_dout;

    assign init_busy = rst ? (INIT_ON_RESET != 0) : (state_q == ST_INIT);

endmodule
`default_nettype wire
